// File: rtl/cdc_fifo_write_arbiter.sv
// cdc_fifo_write_arbiter
//
// Round-robin burst arbiter that shares the single write port of cdc_fifo
// among NUM_REQ requesters, all in the write clock domain. A requester keeps
// the grant for up to MAX_BURST beats, then the grant moves on to the next
// requester with pending data.
//
// Ports:
//   write_clk    in   write-domain clock; all state on its rising edge
//   write_rst    in   asynchronous, active-high reset
//   req_valid    in   [NUM_REQ]            per-requester data valid
//   req_data     in   [NUM_REQ*DATA_WIDTH] requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    out  [NUM_REQ]            per-requester accept (one-hot or zero)
//   fifo_full    in   full flag from cdc_fifo
//   write_enable out  write strobe to cdc_fifo
//   write_data   out  [DATA_WIDTH] write data to cdc_fifo (zero when not writing)
//   grant_valid  out  a requester currently holds the grant (FSM is in BURST)
//   grant_id     out  [ID_WIDTH] index of the granted requester
//
// Handshake: a beat moves from requester i to the FIFO in any cycle where
// req_valid[i] and req_ready[i] are both high. req_ready is combinational
// and only rises for the granted requester while the FIFO is not full, so
// write_enable and req_ready[grant_id] are always the same signal.

module cdc_fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          write_clk,
  input  logic                          write_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic [ID_WIDTH-1:0]  last_q, last_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [ID_WIDTH-1:0]  scan_idx;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic                 pick_found;
  logic                 gnt_valid;
  logic                 xfer;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Unpack the flat requester data bus.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin pick: scan from last+1 upward with wrap-around; the
  // last-served requester is visited last, so it only wins when alone.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    scan_idx   = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_WIDTH'((int'(last_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign gnt_valid = req_valid[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          count_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        xfer = gnt_valid && !fifo_full;
        if (!gnt_valid) begin
          // Withdrawal ends the burst even while the FIFO is full.
          state_d = IDLE;
          last_d  = grant_q;
        end else if (xfer) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge write_clk or posedge write_rst) begin
    if (write_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(NUM_REQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Outputs are decoded from registered state plus live inputs, so an
  // asynchronous reset clears them without waiting for a clock edge.
  assign grant_valid  = (state_q == BURST);
  assign grant_id     = grant_q;
  assign write_enable = xfer;
  assign req_ready    = xfer ? (NUM_REQ'(1) << grant_q) : '0;
  assign write_data   = xfer ? data_arr[grant_q] : '0;

endmodule

// File: doc/cdc_fifo_write_arbiter.md
Name: cdc_fifo_write_arbiter

Overview:
- Round-robin burst arbiter that shares the single write port of cdc_fifo among NUM_REQ requesters in the write clock domain.
- Each requester offers data through a valid/ready handshake.
- Drives write_enable/write_data into the FIFO and never issues a write while fifo_full is high.
- Sits directly upstream of cdc_fifo; the read side is unaffected.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: data width; must match cdc_fifo.
- MAX_BURST, 4: maximum beats per grant (1..16).
- ID_WIDTH, 2: width of grant_id; equals clog2(NUM_REQ).

Ports:
- write_clk  input  1: the single clock (write domain); all state on its rising edge.
- write_rst  input  1: asynchronous, active-high reset.
- req_valid  input  NUM_REQ: per-requester data valid.
- req_data  input  NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ: per-requester accept; one-hot or zero.
- fifo_full  input  1: full flag from cdc_fifo.
- write_enable  output  1: write strobe to cdc_fifo.
- write_data  output  DATA_WIDTH: write data to cdc_fifo.
- grant_valid  output  1: a requester currently holds the grant.
- grant_id  output  ID_WIDTH: index of the granted requester.

Behaviour:
- Interface decision: one clock, write_clk; reset write_rst is asynchronous and active-high.
- Reset values:
  - grant_valid=0, grant_id=0, req_ready=0, write_enable=0, write_data=0.
  - Internal last-served pointer = NUM_REQ-1, so requester 0 wins first.
  - Beat counter = 0; state = IDLE.
- State machine: IDLE, BURST.
  - IDLE: if any req_valid, select the first set bit searching from (last+1) mod NUM_REQ upward with wrap-around. Register grant_id, set grant_valid=1, clear the beat counter, go to BURST.
  - IDLE with no req_valid: stay in IDLE.
  - Arbitration costs one cycle: the first beat transfers at the earliest one cycle after req_valid is first seen in IDLE.
- BURST, per cycle, with g = grant_id:
  - Transfer condition: req_valid[g] && !fifo_full.
  - On a transfer: req_ready[g]=1 and write_enable=1 in the same cycle (combinational); write_data = req_data[g]; beat counter increments.
  - fifo_full high: req_ready=0, write_enable=0. Grant and counter hold (stall); stalled cycles do not count as beats.
  - Exit when the transfer that makes count reach MAX_BURST completes, or when req_valid[g]=0 in a cycle where fifo_full=0.
  - On exit: last=g, grant_valid=0, return to IDLE. The next grant needs the IDLE arbitration cycle, giving one bubble between grants.
  - req_valid[g] dropping while fifo_full=1 is treated as requester withdrawal: exit with no write.
- Data gating: write_data = 0 whenever write_enable = 0. This keeps cdc_fifo inputs quiet and traces deterministic.
- Invariants:
  - Never write_enable && fifo_full.
  - req_ready has at most one bit set, only for the granted requester, and only equal to write_enable.
  - Requester handshake: a requester holds req_data stable while req_valid is high and req_ready is low.
- Fairness: with all requesters permanently valid, grants cycle 0,1,2,3,0,...; each gets MAX_BURST beats per round. No starvation.
- Async reset mid-burst: all outputs drop to reset values immediately, not waiting for a clock edge. The partial burst is abandoned; beats already written stay in the FIFO.
- Deassertion of write_rst is synchronized externally to write_clk. The block takes no action until the first clock edge after release.

Test Plan:
- Reset then single requester: req_valid=4'b0001, data 01..06, fifo_full=0 → beats 01,02,03,04 written on consecutive cycles. grant drops, one IDLE bubble, then a new grant to requester 0 writes 05,06.
- All four valid with distinct data (req i sends 8'hi0+n) → grant_id sequence 0,1,2,3,0. Exactly 4 write_enable pulses per grant. Never two req_ready bits set.
- Burst to requester 2 with fifo_full forced high for 3 cycles after beat 2 → write_enable=0 and req_ready=0 for those 3 cycles. Grant held. Beats 3–4 resume afterwards; the FIFO receives no duplicate or lost data.
- Requester 1 drops req_valid after beat 2 (MAX_BURST=4) → burst ends after 2 writes. Next IDLE cycle grants requester 2 (valid), not requester 1.
- Connect to cdc_fifo (depth 8), four requesters writing continuously, read_enable=0 → exactly 8 writes accepted. fifo_full asserts, no write_enable while full. Reading back yields the 8 values in grant order.
- Assert write_rst asynchronously (between clock edges) in the middle of a burst → write_enable, req_ready and grant_valid go to 0 immediately. After release, the first grant goes to requester 0.
